// File: rtl/data_memory_param.sv
// data_memory_param
// Multi-cycle, byte-addressed, little-endian data memory for the MEM stage.
// It handles all RV32 load/store widths and stalls the pipeline through
// BUSYWAIT for LATENCY+1 cycles per access. Faulted accesses are reported
// by a one-cycle ERROR pulse during the DONE cycle.
//
// Ports:
//   CLK        in   1   rising-edge clock
//   RESET      in   1   asynchronous active-high reset (clears memory too)
//   READ       in   1   load request, held until BUSYWAIT falls
//   WRITE      in   1   store request, held until BUSYWAIT falls
//   FUNCT3     in   3   RV32 load/store funct3
//   ADDRESS    in  32   byte address
//   WRITEDATA  in  32   store data (SB uses [7:0], SH uses [15:0])
//   READDATA   out 32   registered, extended load result
//   BUSYWAIT   out  1   combinational stall request
//   ERROR      out  1   one-cycle fault pulse, only in DONE
module data_memory_param #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITEDATA,
  output logic [31:0] READDATA,
  output logic        BUSYWAIT,
  output logic        ERROR
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // A LATENCY of 1 needs a counter that only ever holds 0; keep it 1 bit wide.
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_isWrite;
  logic [2:0]            r_funct3;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_readData;
  logic                  r_error;
  logic [7:0]            r_mem [DEPTH];

  logic [ADDR_WIDTH-1:0] w_idx0;
  logic [ADDR_WIDTH-1:0] w_idx1;
  logic [ADDR_WIDTH-1:0] w_idx2;
  logic [ADDR_WIDTH-1:0] w_idx3;
  logic [7:0]            w_b0;
  logic [7:0]            w_b1;
  logic [7:0]            w_b2;
  logic [7:0]            w_b3;
  logic                  w_outOfRange;
  logic                  w_misaligned;
  logic                  w_badFunct3;
  logic                  w_fault;
  logic                  w_commit;
  logic                  w_memWrite;
  logic [31:0]           w_loadVal;

  // Byte lanes of the latched address. The +1..+3 indices wrap inside the
  // array; they are only consumed for aligned, in-range accesses where no
  // wrap can occur, so the wrap merely keeps the indexing legal.
  assign w_idx0 = r_addr[ADDR_WIDTH-1:0];
  assign w_idx1 = w_idx0 + ADDR_WIDTH'(1);
  assign w_idx2 = w_idx0 + ADDR_WIDTH'(2);
  assign w_idx3 = w_idx0 + ADDR_WIDTH'(3);
  assign w_b0   = r_mem[w_idx0];
  assign w_b1   = r_mem[w_idx1];
  assign w_b2   = r_mem[w_idx2];
  assign w_b3   = r_mem[w_idx3];

  // Fault detection on the latched request. funct3[1:0] encodes the size:
  // 00 byte, 01 half, 10 word, 11 never legal.
  assign w_outOfRange = |r_addr[31:ADDR_WIDTH];
  assign w_misaligned = ((r_funct3[1:0] == 2'b01) && r_addr[0]) ||
                        ((r_funct3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
  assign w_badFunct3  = r_isWrite ? !(r_funct3 inside {3'b000, 3'b001, 3'b010})
                                  : !(r_funct3 inside {3'b000, 3'b001, 3'b010,
                                                       3'b100, 3'b101});
  assign w_fault      = w_outOfRange || w_misaligned || w_badFunct3;

  assign w_commit   = (r_state == ST_BUSY) && (r_cnt == '0);
  assign w_memWrite = w_commit && r_isWrite && !w_fault;

  // Load result with sign/zero extension selected by funct3.
  always_comb begin
    w_loadVal = 32'h0;
    case (r_funct3)
      3'b000:  w_loadVal = {{24{w_b0[7]}}, w_b0};
      3'b001:  w_loadVal = {{16{w_b1[7]}}, w_b1, w_b0};
      3'b010:  w_loadVal = {w_b3, w_b2, w_b1, w_b0};
      3'b100:  w_loadVal = {24'h0, w_b0};
      3'b101:  w_loadVal = {16'h0, w_b1, w_b0};
      default: w_loadVal = 32'h0;
    endcase
  end

  // Control FSM. The request is latched on leaving IDLE so later input
  // changes cannot corrupt it; DONE never latches, which lets the pipeline
  // advance past a request it is still holding for this cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_isWrite  <= 1'b0;
      r_funct3   <= 3'b000;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_readData <= 32'h0;
      r_error    <= 1'b0;
    end else begin
      r_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (READ || WRITE) begin
            r_isWrite <= WRITE;
            r_funct3  <= FUNCT3;
            r_addr    <= ADDRESS;
            r_wdata   <= WRITEDATA;
            r_cnt     <= CNT_W'(LATENCY - 1);
            r_state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state <= ST_DONE;
            r_error <= w_fault;
            if (!r_isWrite) begin
              r_readData <= w_fault ? 32'h0 : w_loadVal;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Storage array. Reset clears every byte, so an access interrupted by
  // reset can never leave partial data behind.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (w_memWrite) begin
      r_mem[w_idx0] <= r_wdata[7:0];
      if (r_funct3[1:0] != 2'b00) begin
        r_mem[w_idx1] <= r_wdata[15:8];
      end
      if (r_funct3[1:0] == 2'b10) begin
        r_mem[w_idx2] <= r_wdata[23:16];
        r_mem[w_idx3] <= r_wdata[31:24];
      end
    end
  end

  // Stall is combinational so it bites in the request cycle itself.
  assign BUSYWAIT = !RESET && (((r_state == ST_IDLE) && (READ || WRITE)) ||
                               (r_state == ST_BUSY));
  assign READDATA = r_readData;
  assign ERROR    = r_error;

endmodule

// File: tb/tb_data_memory_param.sv
// tb_data_memory_param
// Self-checking bench for data_memory_param. Three instances are built with
// LATENCY 2, 1 and 5; they share RESET/FUNCT3/ADDRESS/WRITEDATA but each has
// its own READ/WRITE so only one is ever active. Expected results are pushed
// to a scoreboard queue when a request is driven and popped when the
// instance reaches its DONE cycle.
module tb_data_memory_param;

  logic        clk;
  logic        RESET;
  logic [2:0]  FUNCT3;
  logic [31:0] ADDRESS;
  logic [31:0] WRITEDATA;
  logic        rdV   [3];
  logic        wrV   [3];
  logic [31:0] rdata [3];
  logic        bw    [3];
  logic        err   [3];

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          width;
    string       name;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          width;
    logic        errOutside;
  } obs_t;

  exp_t        sbQ[$];
  logic [31:0] lastRd [3];
  int          lat    [3];
  int          assertCount;
  int          failCount;

  data_memory_param #(.ADDR_WIDTH(10), .LATENCY(2)) dut0 (
    .CLK(clk), .RESET(RESET), .READ(rdV[0]), .WRITE(wrV[0]), .FUNCT3(FUNCT3),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(rdata[0]),
    .BUSYWAIT(bw[0]), .ERROR(err[0]));

  data_memory_param #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
    .CLK(clk), .RESET(RESET), .READ(rdV[1]), .WRITE(wrV[1]), .FUNCT3(FUNCT3),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(rdata[1]),
    .BUSYWAIT(bw[1]), .ERROR(err[1]));

  data_memory_param #(.ADDR_WIDTH(10), .LATENCY(5)) dut2 (
    .CLK(clk), .RESET(RESET), .READ(rdV[2]), .WRITE(wrV[2]), .FUNCT3(FUNCT3),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(rdata[2]),
    .BUSYWAIT(bw[2]), .ERROR(err[2]));

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request on instance k, pushes its expectation, and measures
  // BUSYWAIT width, DONE-cycle READDATA/ERROR and any ERROR seen outside
  // DONE (during the busy cycles or the cycle after DONE). Inputs change on
  // the falling edge; outputs are sampled 1 unit after the rising edge.
  task automatic applyStimulus(input int k, input logic doRead, input logic doWrite,
                               input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [31:0] expLoad,
                               input logic expErr, input string name,
                               input logic noSync, output obs_t o);
    exp_t e;
    logic done;
    e.err   = expErr;
    e.width = lat[k] + 1;
    e.name  = name;
    if (doWrite) begin
      e.data = lastRd[k];
    end else begin
      e.data    = expLoad;
      lastRd[k] = expLoad;
    end
    sbQ.push_back(e);
    if (!noSync) @(negedge clk);
    FUNCT3    = f3;
    ADDRESS   = addr;
    WRITEDATA = wd;
    rdV[k]    = doRead;
    wrV[k]    = doWrite;
    #1;
    o.width      = bw[k] ? 1 : 0;
    o.errOutside = err[k];
    done         = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(posedge clk); #1;
      if (bw[k]) begin
        o.width++;
        o.errOutside |= err[k];
      end else begin
        done = 1'b1;
      end
    end
    rdV[k] = 1'b0;
    wrV[k] = 1'b0;
    o.data = rdata[k];
    o.err  = err[k];
    @(posedge clk); #1;
    o.errOutside |= err[k];
  endtask

  task automatic test_reset;
    obs_t o;
    exp_t e;
    @(negedge clk);
    rdV[0]  = 1'b1;
    FUNCT3  = 3'b010;
    ADDRESS = 32'h0;
    #1;
    assertCount++;
    if (bw[0] !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busywait got %b expected 0", bw[0]); end
    assertCount++;
    if (rdata[0] !== 32'h0) begin failCount++; $display("[TB] FAIL reset_readdata got %h expected 00000000", rdata[0]); end
    assertCount++;
    if (err[0] !== 1'b0) begin failCount++; $display("[TB] FAIL reset_error got %b expected 0", err[0]); end
    // Release reset with READ still held: the request restarts from IDLE.
    @(negedge clk);
    RESET = 1'b0;
    applyStimulus(0, 1, 0, 3'b010, 32'h0, 32'h0, 32'h0, 0, "lw_after_reset", 1, o);
    e = sbQ.pop_front();
    assertCount++;
    if (o.data !== e.data) begin failCount++; $display("[TB] FAIL %s readdata got %h expected %h", e.name, o.data, e.data); end
    assertCount++;
    if (o.width !== e.width) begin failCount++; $display("[TB] FAIL %s busy_width got %0d expected %0d", e.name, o.width, e.width); end
  endtask

  task automatic test_word_rw;
    obs_t o;
    exp_t e;
    applyStimulus(0, 0, 1, 3'b010, 32'h10, 32'h8badf00d, 32'h0, 0, "sw_0x010", 0, o);
    e = sbQ.pop_front();
    assertCount++;
    if (o.width !== e.width) begin failCount++; $display("[TB] FAIL %s busy_width got %0d expected %0d", e.name, o.width, e.width); end
    assertCount++;
    if (o.data !== e.data) begin failCount++; $display("[TB] FAIL %s readdata got %h expected %h", e.name, o.data, e.data); end
    assertCount++;
    if (o.err !== e.err || o.errOutside !== 1'b0) begin failCount++; $display("[TB] FAIL %s error got %b/%b expected %b/0", e.name, o.err, o.errOutside, e.err); end
    applyStimulus(0, 1, 0, 3'b010, 32'h10, 32'h0, 32'h8badf00d, 0, "lw_0x010", 0, o);
    e = sbQ.pop_front();
    assertCount++;
    if (o.width !== e.width) begin failCount++; $display("[TB] FAIL %s busy_width got %0d expected %0d", e.name, o.width, e.width); end
    assertCount++;
    if (o.data !== e.data) begin failCount++; $display("[TB] FAIL %s readdata got %h expected %h", e.name, o.data, e.data); end
    assertCount++;
    if (o.err !== e.err || o.errOutside !== 1'b0) begin failCount++; $display("[TB] FAIL %s error got %b/%b expected %b/0", e.name, o.err, o.errOutside, e.err); end
  endtask

  task automatic test_subword_loads;
    logic [2:0]  f3Tab   [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] addrTab [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [31:0] expTab  [4] = '{32'hffffff8b, 32'h0000008b, 32'hffff8bad, 32'h0000f00d};
    obs_t o;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, f3Tab[i], addrTab[i], 32'h0, expTab[i], 0, $sformatf("subload_%0d", i), 0, o);
      e = sbQ.pop_front();
      assertCount++;
      if (o.data !== e.data || o.err !== e.err) begin
        failCount++;
        $display("[TB] FAIL %s readdata/error got %h/%b expected %h/%b", e.name, o.data, o.err, e.data, e.err);
      end
    end
  endtask

  task automatic test_byte_store;
    obs_t o;
    exp_t e;
    applyStimulus(0, 0, 1, 3'b000, 32'h11, 32'hdeadbe55, 32'h0, 0, "sb_0x011", 0, o);
    e = sbQ.pop_front();
    assertCount++;
    if (o.data !== e.data || o.err !== e.err) begin failCount++; $display("[TB] FAIL %s readdata/error got %h/%b expected %h/%b", e.name, o.data, o.err, e.data, e.err); end
    applyStimulus(0, 1, 0, 3'b010, 32'h10, 32'h0, 32'h8bad550d, 0, "lw_after_sb", 0, o);
    e = sbQ.pop_front();
    assertCount++;
    if (o.data !== e.data || o.err !== e.err) begin failCount++; $display("[TB] FAIL %s readdata/error got %h/%b expected %h/%b", e.name, o.data, o.err, e.data, e.err); end
  endtask

  task automatic test_faults;
    logic        rdTab   [6] = '{0, 1, 1, 1, 0, 1};
    logic [2:0]  f3Tab   [6] = '{3'b001, 3'b010, 3'b010, 3'b011, 3'b100, 3'b010};
    logic [31:0] addrTab [6] = '{32'h11, 32'h10, 32'h402, 32'h10, 32'h10, 32'h10};
    logic [31:0] wdTab   [6] = '{32'h0000ffff, 32'h0, 32'h0, 32'h0, 32'h11111111, 32'h0};
    logic [31:0] expTab  [6] = '{32'h0, 32'h8bad550d, 32'h0, 32'h0, 32'h0, 32'h8bad550d};
    logic        errTab  [6] = '{1, 0, 1, 1, 1, 0};
    obs_t o;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, rdTab[i], !rdTab[i], f3Tab[i], addrTab[i], wdTab[i], expTab[i], errTab[i],
                    $sformatf("fault_%0d", i), 0, o);
      e = sbQ.pop_front();
      assertCount++;
      if (o.data !== e.data) begin failCount++; $display("[TB] FAIL %s readdata got %h expected %h", e.name, o.data, e.data); end
      assertCount++;
      if (o.err !== e.err || o.errOutside !== 1'b0) begin failCount++; $display("[TB] FAIL %s error got %b/%b expected %b/0", e.name, o.err, o.errOutside, e.err); end
    end
    applyStimulus(0, 1, 0, 3'b010, 32'h80000010, 32'h0, 32'h0, 1, "lw_high_addr", 0, o);
    e = sbQ.pop_front();
    assertCount++;
    if (o.err !== e.err || o.data !== e.data) begin failCount++; $display("[TB] FAIL %s readdata/error got %h/%b expected %h/%b", e.name, o.data, o.err, e.data, e.err); end
  endtask

  task automatic test_both_high;
    obs_t o;
    exp_t e;
    applyStimulus(0, 1, 1, 3'b010, 32'h30, 32'h12345678, 32'h0, 0, "rw_both_high", 0, o);
    e = sbQ.pop_front();
    assertCount++;
    if (o.data !== e.data || o.err !== e.err) begin failCount++; $display("[TB] FAIL %s readdata/error got %h/%b expected %h/%b", e.name, o.data, o.err, e.data, e.err); end
    applyStimulus(0, 1, 0, 3'b010, 32'h30, 32'h0, 32'h12345678, 0, "lw_after_both", 0, o);
    e = sbQ.pop_front();
    assertCount++;
    if (o.data !== e.data || o.err !== e.err) begin failCount++; $display("[TB] FAIL %s readdata/error got %h/%b expected %h/%b", e.name, o.data, o.err, e.data, e.err); end
  endtask

  task automatic test_latency;
    logic [31:0] expTab [6] = '{32'h0, 32'hcafef00d, 32'hffffcafe, 32'h0, 32'h0000beef, 32'hbeef0000};
    obs_t o;
    exp_t e;
    applyStimulus(1, 0, 1, 3'b010, 32'h08, 32'hcafef00d, 32'h0, 0, "lat1_sw", 0, o);
    e = sbQ.pop_front();
    assertCount++;
    if (o.width !== e.width || o.data !== e.data) begin failCount++; $display("[TB] FAIL %s width/readdata got %0d/%h expected %0d/%h", e.name, o.width, o.data, e.width, e.data); end
    applyStimulus(1, 1, 0, 3'b010, 32'h08, 32'h0, expTab[1], 0, "lat1_lw", 0, o);
    e = sbQ.pop_front();
    assertCount++;
    if (o.width !== e.width || o.data !== e.data) begin failCount++; $display("[TB] FAIL %s width/readdata got %0d/%h expected %0d/%h", e.name, o.width, o.data, e.width, e.data); end
    applyStimulus(1, 1, 0, 3'b001, 32'h0a, 32'h0, expTab[2], 0, "lat1_lh", 0, o);
    e = sbQ.pop_front();
    assertCount++;
    if (o.width !== e.width || o.data !== e.data) begin failCount++; $display("[TB] FAIL %s width/readdata got %0d/%h expected %0d/%h", e.name, o.width, o.data, e.width, e.data); end
    applyStimulus(2, 0, 1, 3'b001, 32'h06, 32'h1234beef, 32'h0, 0, "lat5_sh", 0, o);
    e = sbQ.pop_front();
    assertCount++;
    if (o.width !== e.width || o.data !== e.data) begin failCount++; $display("[TB] FAIL %s width/readdata got %0d/%h expected %0d/%h", e.name, o.width, o.data, e.width, e.data); end
    applyStimulus(2, 1, 0, 3'b101, 32'h06, 32'h0, expTab[4], 0, "lat5_lhu", 0, o);
    e = sbQ.pop_front();
    assertCount++;
    if (o.width !== e.width || o.data !== e.data) begin failCount++; $display("[TB] FAIL %s width/readdata got %0d/%h expected %0d/%h", e.name, o.width, o.data, e.width, e.data); end
    applyStimulus(2, 1, 0, 3'b010, 32'h04, 32'h0, expTab[5], 0, "lat5_lw", 0, o);
    e = sbQ.pop_front();
    assertCount++;
    if (o.width !== e.width || o.data !== e.data || o.errOutside !== 1'b0) begin failCount++; $display("[TB] FAIL %s width/readdata got %0d/%h expected %0d/%h", e.name, o.width, o.data, e.width, e.data); end
  endtask

  task automatic test_reset_mid_access;
    obs_t o;
    exp_t e;
    @(negedge clk);
    FUNCT3    = 3'b010;
    ADDRESS   = 32'h20;
    WRITEDATA = 32'hffffffff;
    wrV[0]    = 1'b1;
    @(posedge clk); #1;
    assertCount++;
    if (bw[0] !== 1'b1) begin failCount++; $display("[TB] FAIL midreset_busy got %b expected 1", bw[0]); end
    RESET  = 1'b1;
    wrV[0] = 1'b0;
    #1;
    assertCount++;
    if (bw[0] !== 1'b0 || rdata[0] !== 32'h0 || err[0] !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midreset_outputs got bw=%b rd=%h err=%b expected 0/00000000/0", bw[0], rdata[0], err[0]);
    end
    @(negedge clk);
    RESET = 1'b0;
    for (int k = 0; k < 3; k++) lastRd[k] = 32'h0;
    applyStimulus(0, 1, 0, 3'b010, 32'h20, 32'h0, 32'h0, 0, "lw_after_midreset", 0, o);
    e = sbQ.pop_front();
    assertCount++;
    if (o.data !== e.data || o.err !== e.err) begin failCount++; $display("[TB] FAIL %s readdata/error got %h/%b expected %h/%b", e.name, o.data, o.err, e.data, e.err); end
    applyStimulus(0, 1, 0, 3'b010, 32'h10, 32'h0, 32'h0, 0, "lw_cleared_0x010", 0, o);
    e = sbQ.pop_front();
    assertCount++;
    if (o.data !== e.data || o.err !== e.err) begin failCount++; $display("[TB] FAIL %s readdata/error got %h/%b expected %h/%b", e.name, o.data, o.err, e.data, e.err); end
  endtask

  // Runs every scenario in order and prints the summary line.
  initial begin
    assertCount = 0;
    failCount   = 0;
    lat[0] = 2;
    lat[1] = 1;
    lat[2] = 5;
    RESET     = 1'b1;
    FUNCT3    = 3'b000;
    ADDRESS   = 32'h0;
    WRITEDATA = 32'h0;
    for (int k = 0; k < 3; k++) begin
      rdV[k]    = 1'b0;
      wrV[k]    = 1'b0;
      lastRd[k] = 32'h0;
    end
    repeat (2) @(negedge clk);
    test_reset();
    test_word_rw();
    test_subword_loads();
    test_byte_store();
    test_faults();
    test_both_high();
    test_latency();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/data_memory_param.md
# data_memory_param

Parametrised, multi-cycle data memory for the RV32IM pipeline's MEM stage. It is byte-addressed and little-endian, holding 2^ADDR_WIDTH bytes. It executes all RV32 load/store widths (LB/LH/LW/LBU/LHU/SB/SH/SW) with correct sign/zero extension, stalls the pipeline through a BUSYWAIT handshake for a configurable access latency, and reports misaligned, illegal or out-of-range accesses on a one-cycle ERROR pulse.

## Interface
Parameters:
- ADDR_WIDTH, 10, byte-address width; depth = 2^ADDR_WIDTH bytes (range 2..20)
- LATENCY, 2, number of BUSY cycles per access (must be ≥1)

Ports:
- CLK  input  1  clock; all state changes on the rising edge
- RESET  input  1  asynchronous, active-high reset
- READ  input  1  load request; held by the requester until BUSYWAIT falls
- WRITE  input  1  store request; same holding rule as READ
- FUNCT3  input  3  RV32 load/store funct3
- ADDRESS  input  32  byte address
- WRITEDATA  input  32  store data; SB uses [7:0], SH uses [15:0]
- READDATA  output  32  extended load result; registered
- BUSYWAIT  output  1  stall request to the pipeline
- ERROR  output  1  one-cycle pulse flagging a faulted access

## Operation
- FSM states: IDLE, BUSY, DONE. Down-counter cnt is wide enough to hold LATENCY-1.
- IDLE: if READ or WRITE is high at a rising edge, latch op, FUNCT3, ADDRESS and WRITEDATA, load cnt = LATENCY-1, and go to BUSY. Input changes after latching are ignored.
- Both READ and WRITE high: the access is a write, and READDATA is unchanged.
- BUSY: if cnt ≠ 0, decrement. If cnt = 0, perform the access at that edge, then go to DONE.
- DONE: lasts one cycle, then IDLE unconditionally. The DONE cycle never latches a new request, so the pipeline can advance without re-issuing the same request.
- BUSYWAIT = !RESET && ((IDLE && (READ||WRITE)) || BUSY). It is combinational so the stall takes effect in the request cycle. It is low in DONE.
- Byte index = latched ADDRESS[ADDR_WIDTH-1:0], little-endian: byte at A is bits [7:0], A+1 is bits [15:8], and so on.
- Loads:
  - 000 LB: sign-extend byte
  - 001 LH: sign-extend half
  - 010 LW: full word
  - 100 LBU: zero-extend byte
  - 101 LHU: zero-extend half
- Stores: 000 SB writes 1 byte, 001 SH writes 2 bytes, 010 SW writes 4 bytes.
- Fault conditions, checked on the latched request:
  - ADDRESS[31:ADDR_WIDTH] ≠ 0 (out of range; addresses never wrap)
  - halfword access with ADDRESS[0] = 1
  - word access with ADDRESS[1:0] ≠ 0
  - funct3 not listed above for the op
- On a fault: no memory write, READDATA ← 0 for loads, ERROR = 1 during the DONE cycle.
- READDATA holds its value until the next load completes. Stores never alter it.
- RESET (asynchronous): state ← IDLE, cnt ← 0, READDATA ← 0, ERROR ← 0, BUSYWAIT ← 0, every memory byte ← 0.
- Reset mid-access: the pending access is abandoned and memory is unmodified by it. After RESET falls, a still-asserted request restarts from IDLE.

## Timing
- Request present in cycle 0 (IDLE). BUSYWAIT is high for cycles 0..LATENCY, i.e. LATENCY+1 cycles.
- The access commits at the rising edge ending cycle LATENCY.
- Cycle LATENCY+1 is DONE: BUSYWAIT = 0, READDATA valid, ERROR valid.
- Earliest next request is cycle LATENCY+2. Back-to-back throughput is one access per LATENCY+2 cycles.
- A load following a store to the same address returns the stored data, since the store has committed before the load is latched.
- ERROR is never high outside DONE.

## Test plan
- Reset with READ held high → BUSYWAIT = 0, READDATA = 0x00000000; after release, LW @0x000 returns 0x00000000.
- LATENCY = 2: SW 0x8badf00d @0x010, then LW @0x010 → BUSYWAIT high for exactly 3 cycles per access; READDATA = 0x8badf00d in DONE; ERROR = 0.
- Byte and half loads of that word:
  - LB @0x013 → 0xffffff8b
  - LBU @0x013 → 0x0000008b
  - LH @0x012 → 0xffff8bad
  - LHU @0x010 → 0x0000f00d
- SB 0x55 @0x011, then LW @0x010 → 0x8bad550d.
- Faults:
  - SH @0x011 → ERROR pulses 1 cycle, memory unchanged.
  - LW @0x402 (ADDR_WIDTH = 10) → ERROR pulses, READDATA = 0.
  - FUNCT3 = 011 load → ERROR pulses.
- Assert RESET during the BUSY cycle of SW 0xffffffff @0x020 → after reset, LW @0x020 = 0x00000000. Also rerun LATENCY = 1 and 5: check BUSYWAIT width is 2 and 6 cycles.
